// File: rtl/loop_nest_issuer.sv
// Iteration generator for a DIMS-deep perfectly nested loop. It issues one index tuple every II
// cycles, supports stalls, and can restart seamlessly on the final iteration.
module loop_nest_issuer #(
    parameter int unsigned DIMS = 2,
    parameter int unsigned W    = 16,
    parameter logic [DIMS*W-1:0] TRIP = {16'd2, 16'd3},
    parameter int unsigned II   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic [DIMS*W-1:0] idx,
    output logic              valid,
    output logic              first,
    output logic              last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned PW = (II > 1) ? $clog2(II) : 1;
    localparam logic [PW-1:0] PHASE_MAX = PW'(II - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [DIMS*W-1:0]  idx_q, idx_d, idx_inc;
    logic [PW-1:0]      phase_q, phase_d;
    logic               done_q, done_d;
    logic [DIMS-1:0]    at_max;
    logic               zero_trip;
    logic               is_last;
    logic               is_first;

    always_comb begin
        zero_trip = 1'b0;
        for (int d = 0; d < int'(DIMS); d++) begin
            if (TRIP[d*W +: W] == '0) zero_trip = 1'b1;
            at_max[d] = (idx_q[d*W +: W] == TRIP[d*W +: W] - W'(1));
        end
    end

    // Mixed-radix increment: each dim at its maximum wraps to 0 and passes the carry on.
    always_comb begin
        logic carry;
        carry   = 1'b1;
        idx_inc = idx_q;
        for (int d = 0; d < int'(DIMS); d++) begin
            if (carry) begin
                if (at_max[d]) begin
                    idx_inc[d*W +: W] = '0;
                end else begin
                    idx_inc[d*W +: W] = idx_q[d*W +: W] + W'(1);
                    carry = 1'b0;
                end
            end
        end
    end

    always_comb begin
        is_last  = &at_max;
        is_first = (idx_q == '0);
        busy     = (state_q == StRun);
        valid    = busy && (phase_q == '0) && !stall;
        first    = valid && is_first;
        last     = valid && is_last;
        done     = done_q;
        idx      = idx_q;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (zero_trip) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StRun;
                        idx_d   = '0;
                        phase_d = '0;
                    end
                end
            end
            StRun: begin
                if (!stall) begin
                    phase_d = (phase_q == PHASE_MAX) ? '0 : phase_q + PW'(1);
                end
                if (valid) begin
                    if (is_last) begin
                        // A start coinciding with the final issue keeps RUN for a fresh nest.
                        done_d  = 1'b1;
                        idx_d   = '0;
                        phase_d = '0;
                        state_d = start ? StRun : StIdle;
                    end else begin
                        idx_d = idx_inc;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            phase_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_loop_nest_issuer.sv
// Bench for loop_nest_issuer: directed vector tables over several configurations, then random
// start/stall/reset traffic checked against an arithmetic iteration model.
module tb_loop_nest_issuer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  rst_v, start_v, stall_v, valid_v, first_v, last_v, busy_v, done_v;
    logic [31:0] idx0, idx1, idx2, idx3;
    logic [47:0] idx4;
    logic [47:0] idx_all [5];

    assign idx_all[0] = {16'd0, idx0};
    assign idx_all[1] = {16'd0, idx1};
    assign idx_all[2] = {16'd0, idx2};
    assign idx_all[3] = {16'd0, idx3};
    assign idx_all[4] = idx4;

    loop_nest_issuer #(.DIMS(2), .W(16), .TRIP({16'd2, 16'd3}), .II(1)) u_a (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .stall(stall_v[0]), .idx(idx0),
        .valid(valid_v[0]), .first(first_v[0]), .last(last_v[0]), .busy(busy_v[0]),
        .done(done_v[0]));
    loop_nest_issuer #(.DIMS(2), .W(16), .TRIP({16'd2, 16'd3}), .II(3)) u_b (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .stall(stall_v[1]), .idx(idx1),
        .valid(valid_v[1]), .first(first_v[1]), .last(last_v[1]), .busy(busy_v[1]),
        .done(done_v[1]));
    loop_nest_issuer #(.DIMS(2), .W(16), .TRIP({16'd2, 16'd0}), .II(1)) u_c (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .stall(stall_v[2]), .idx(idx2),
        .valid(valid_v[2]), .first(first_v[2]), .last(last_v[2]), .busy(busy_v[2]),
        .done(done_v[2]));
    loop_nest_issuer #(.DIMS(2), .W(16), .TRIP({16'd1, 16'd2}), .II(1)) u_d (
        .clk(clk), .rst(rst_v[3]), .start(start_v[3]), .stall(stall_v[3]), .idx(idx3),
        .valid(valid_v[3]), .first(first_v[3]), .last(last_v[3]), .busy(busy_v[3]),
        .done(done_v[3]));
    loop_nest_issuer #(.DIMS(3), .W(16), .TRIP({16'd2, 16'd1, 16'd3}), .II(2)) u_e (
        .clk(clk), .rst(rst_v[4]), .start(start_v[4]), .stall(stall_v[4]), .idx(idx4),
        .valid(valid_v[4]), .first(first_v[4]), .last(last_v[4]), .busy(busy_v[4]),
        .done(done_v[4]));

    typedef struct {
        int          sel;
        bit          rst, start, stall;
        bit          v, f, l, b, d;
        logic [47:0] idx;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   trips [3] = '{3, 1, 2};

    task automatic add(input int sel, input bit r, s, st, v, f, l, b, d, input logic [47:0] ix);
        vec_t t;
        t.sel = sel; t.rst = r; t.start = s; t.stall = st;
        t.v = v; t.f = f; t.l = l; t.b = b; t.d = d; t.idx = ix;
        vecs.push_back(t);
    endtask

    function automatic logic [47:0] ix2(input int d1, input int d0);
        logic [47:0] r;
        r = '0;
        r[31:16] = d1[15:0];
        r[15:0]  = d0[15:0];
        return r;
    endfunction

    // Iteration number to index tuple for the 3-deep random configuration.
    function automatic logic [47:0] decomp(input int n);
        logic [47:0] r;
        int q;
        r = '0;
        q = n;
        for (int d = 0; d < 3; d++) begin
            r[d*16 +: 16] = 16'(q % trips[d]);
            q = q / trips[d];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input bit r, input bit s, input bit st);
        @(negedge clk);
        rst_v = '0; start_v = '0; stall_v = '0;
        rst_v[sel] = r; start_v[sel] = s; stall_v[sel] = st;
        #1;
    endtask

    task automatic chk_all(input string tag, input int sel, input bit v, f, l, b, d,
                           input logic [47:0] ix);
        chk({tag, " valid"}, 48'(valid_v[sel]), 48'(v));
        chk({tag, " first"}, 48'(first_v[sel]), 48'(f));
        chk({tag, " last"},  48'(last_v[sel]),  48'(l));
        chk({tag, " busy"},  48'(busy_v[sel]),  48'(b));
        chk({tag, " done"},  48'(done_v[sel]),  48'(d));
        chk({tag, " idx"},   idx_all[sel], ix);
    endtask

    initial begin
        bit m_run, m_done, r, s, st, ev;
        int m_n, m_gap;
        int nprod;

        // dut0, II=1: plain run
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) add(0, 0, 0, 0, 1, k == 0, k == 5, 1, 0, ix2(k / 3, k % 3));
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // dut1, II=3
        add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 16; c++) begin
            int k;
            bit v;
            k = (c + 1) / 3;
            v = ((c - 1) % 3 == 0);
            add(1, 0, 0, 0, v, v && k == 0, v && k == 5, 1, 0, ix2(k / 3, k % 3));
        end
        add(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // dut0, stall cycles 3-4
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 1, 0, ix2(0, 0));
        add(0, 0, 0, 0, 1, 0, 0, 1, 0, ix2(0, 1));
        add(0, 0, 0, 1, 0, 0, 0, 1, 0, ix2(0, 2));
        add(0, 0, 0, 1, 0, 0, 0, 1, 0, ix2(0, 2));
        add(0, 0, 0, 0, 1, 0, 0, 1, 0, ix2(0, 2));
        add(0, 0, 0, 0, 1, 0, 0, 1, 0, ix2(1, 0));
        add(0, 0, 0, 0, 1, 0, 0, 1, 0, ix2(1, 1));
        add(0, 0, 0, 0, 1, 0, 1, 1, 0, ix2(1, 2));
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        // dut2, zero trip count
        add(2, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(2, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // dut3, seamless restart
        add(3, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(3, 0, 0, 0, 1, 1, 0, 1, 0, ix2(0, 0));
        add(3, 0, 1, 0, 1, 0, 1, 1, 0, ix2(0, 1));
        add(3, 0, 0, 0, 1, 1, 0, 1, 1, ix2(0, 0));
        add(3, 0, 0, 0, 1, 0, 1, 1, 0, ix2(0, 1));
        add(3, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // dut0, reset mid-run then fresh start
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 1, 0, ix2(0, 0));
        add(0, 0, 0, 0, 1, 0, 0, 1, 0, ix2(0, 1));
        add(0, 1, 0, 0, 1, 0, 0, 1, 0, ix2(0, 2));
        for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 1, 0, ix2(0, 0));
        add(0, 0, 0, 0, 1, 0, 0, 1, 0, ix2(0, 1));
        add(0, 1, 0, 0, 1, 0, 0, 1, 0, ix2(0, 2));
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // dut0, start mid-run ignored, stall on the final iteration
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 1, 0, ix2(0, 0));
        add(0, 0, 1, 0, 1, 0, 0, 1, 0, ix2(0, 1));
        add(0, 0, 0, 0, 1, 0, 0, 1, 0, ix2(0, 2));
        add(0, 0, 0, 0, 1, 0, 0, 1, 0, ix2(1, 0));
        add(0, 0, 0, 0, 1, 0, 0, 1, 0, ix2(1, 1));
        add(0, 0, 0, 1, 0, 0, 0, 1, 0, ix2(1, 2));
        add(0, 0, 0, 0, 1, 0, 1, 1, 0, ix2(1, 2));
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        rst_v = '1; start_v = '0; stall_v = '0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].sel, vecs[i].rst, vecs[i].start, vecs[i].stall);
            chk_all($sformatf("vec%0d", i), vecs[i].sel, vecs[i].v, vecs[i].f, vecs[i].l,
                    vecs[i].b, vecs[i].d, vecs[i].idx);
        end

        // Random traffic on the 3-deep, II=2 instance.
        nprod  = trips[0] * trips[1] * trips[2];
        m_run  = 1'b0;
        m_done = 1'b0;
        m_n    = 0;
        m_gap  = 0;
        for (int c = 0; c < 800; c++) begin
            r  = ($urandom_range(0, 59) == 0);
            s  = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 2) == 0);
            drive(4, r, s, st);
            ev = m_run && (m_gap == 0) && !st;
            chk_all($sformatf("rnd%0d", c), 4, ev, ev && m_n == 0, ev && m_n == nprod - 1,
                    m_run, m_done, m_run ? decomp(m_n) : 48'd0);
            if (r) begin
                m_run = 1'b0; m_done = 1'b0; m_n = 0; m_gap = 0;
            end else begin
                m_done = 1'b0;
                if (!m_run) begin
                    if (s) begin
                        m_run = 1'b1; m_n = 0; m_gap = 0;
                    end
                end else if (ev) begin
                    if (m_n == nprod - 1) begin
                        m_done = 1'b1;
                        m_n    = 0;
                        m_gap  = 0;
                        m_run  = s;
                    end else begin
                        m_n++;
                        m_gap = 1;
                    end
                end else if (!st && m_gap > 0) begin
                    m_gap--;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
